// File: rtl/tmu2_mult2_arb.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tmu2_mult2_arb
//
// Shares one external 2-stage pipelined unsigned multiplier between two
// requesters. Operand pairs are arbitrated and issued to the multiplier. Each
// issue is tagged with its requester. Each product is returned to its
// originator in issue order. A result that its owner has not consumed stalls
// the whole multiplier pipeline through mul_ce, so no product is ever dropped
// or duplicated.
//
// Configuration macro: TMU2_MULTARB_RR_EN
//   defined   - round-robin between simultaneous requests
//   undefined - fixed priority, requester 0 always wins
//
// Ports
//   sys_clk, sys_rst        clock and synchronous active-high reset
//   busy                    request pending or product in flight
//   s0_stb_i/s0_ack_o       requester 0 operand handshake (ack same cycle)
//   s0_a, s0_b              requester 0 operands
//   s1_stb_i/s1_ack_o       requester 1 operand handshake
//   s1_a, s1_b              requester 1 operands
//   r0_stb_o/r0_ack_i       requester 0 result handshake
//   r1_stb_o/r1_ack_i       requester 1 result handshake
//   r_p                     product bus shared by both result ports
//   mul_ce                  multiplier clock enable
//   mul_a, mul_b            multiplier operands (granted requester)
//   mul_p                   multiplier product, valid 2 ce-cycles after issue
// ---------------------------------------------------------------------------
module tmu2_mult2_arb #(
    parameter int A_WIDTH = 13,
    parameter int B_WIDTH = 13
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst,
    output logic                       busy,

    input  logic                       s0_stb_i,
    output logic                       s0_ack_o,
    input  logic [A_WIDTH-1:0]         s0_a,
    input  logic [B_WIDTH-1:0]         s0_b,

    input  logic                       s1_stb_i,
    output logic                       s1_ack_o,
    input  logic [A_WIDTH-1:0]         s1_a,
    input  logic [B_WIDTH-1:0]         s1_b,

    output logic                       r0_stb_o,
    input  logic                       r0_ack_i,
    output logic                       r1_stb_o,
    input  logic                       r1_ack_i,
    output logic [A_WIDTH+B_WIDTH-1:0] r_p,

    output logic                       mul_ce,
    output logic [A_WIDTH-1:0]         mul_a,
    output logic [B_WIDTH-1:0]         mul_b,
    input  logic [A_WIDTH+B_WIDTH-1:0] mul_p
);

    // Valid/tag pairs shadowing the multiplier's temp (stage 1) and p (stage 2).
    logic v1_q, v1_d;
    logic t1_q, t1_d;
    logic v2_q, v2_d;
    logic t2_q, t2_d;

    logic grant;      // 0 = requester 0, 1 = requester 1
    logic issue;
    logic owner_ack;

`ifdef TMU2_MULTARB_RR_EN
    logic last_q, last_d;  // requester granted on the most recent issue
`endif

    // -----------------------------------------------------------------------
    // Arbitration. With no request pending grant stays 0, which also selects
    // requester 0's operands onto the multiplier bus.
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and infers a latch.
        grant = 1'b0;
`ifdef TMU2_MULTARB_RR_EN
        if (s0_stb_i && s1_stb_i) begin
            grant = ~last_q;
        end else begin
            grant = s1_stb_i;
        end
`else
        grant = ~s0_stb_i & s1_stb_i;
`endif
    end

    // The stage-2 product stalls everything until its owner takes it.
    assign owner_ack = t2_q ? r1_ack_i : r0_ack_i;
    assign mul_ce    = ~sys_rst & (~v2_q | owner_ack);
    assign issue     = mul_ce & (s0_stb_i | s1_stb_i);

    assign s0_ack_o  = issue & ~grant;
    assign s1_ack_o  = issue &  grant;

    assign mul_a     = grant ? s1_a : s0_a;
    assign mul_b     = grant ? s1_b : s0_b;

    // Reset gates the result side combinationally so nothing stale is
    // presented while reset is still being sampled.
    assign r0_stb_o  = ~sys_rst & v2_q & ~t2_q;
    assign r1_stb_o  = ~sys_rst & v2_q &  t2_q;
    assign r_p       = mul_p;

    assign busy      = s0_stb_i | s1_stb_i | (~sys_rst & (v1_q | v2_q));

    // -----------------------------------------------------------------------
    // Tracking pipeline: shifts exactly when the multiplier does.
    // -----------------------------------------------------------------------
    always_comb begin
        v1_d = v1_q;
        t1_d = t1_q;
        v2_d = v2_q;
        t2_d = t2_q;
        if (mul_ce) begin
            v1_d = issue;
            t1_d = grant;
            v2_d = v1_q;
            t2_d = t1_q;
        end
    end

`ifdef TMU2_MULTARB_RR_EN
    // Last-grant only moves on an actual issue, so a stall never rotates
    // priority.
    always_comb begin
        last_d = last_q;
        if (issue) begin
            last_d = grant;
        end
    end
`endif

    always_ff @(posedge sys_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (sys_rst) begin
            v1_q <= 1'b0;
            t1_q <= 1'b0;
            v2_q <= 1'b0;
            t2_q <= 1'b0;
        end else begin
            v1_q <= v1_d;
            t1_q <= t1_d;
            v2_q <= v2_d;
            t2_q <= t2_d;
        end
    end

`ifdef TMU2_MULTARB_RR_EN
    // Reset to 1 so requester 0 wins the first contested issue.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`endif

endmodule

// File: tb/tb_tmu2_mult2_arb.sv
`timescale 1ns/1ps
// Self-checking bench for tmu2_mult2_arb. Includes a behavioural model of the
// external 2-stage multiplier, an issue-side predictor that pushes expected
// products into a scoreboard, and a result-side monitor that pops and checks.
module tb_tmu2_mult2_arb;

    localparam int AW = 13;
    localparam int BW = 13;
    localparam int PW = AW + BW;

    logic          sys_clk = 1'b0;
    logic          sys_rst = 1'b1;
    logic          busy;
    logic          s0_stb_i = 1'b0, s1_stb_i = 1'b0;
    logic          s0_ack_o, s1_ack_o;
    logic [AW-1:0] s0_a = '0, s1_a = '0;
    logic [BW-1:0] s0_b = '0, s1_b = '0;
    logic          r0_stb_o, r1_stb_o;
    logic          r0_ack_i = 1'b1, r1_ack_i = 1'b1;
    logic [PW-1:0] r_p;
    logic          mul_ce;
    logic [AW-1:0] mul_a;
    logic [BW-1:0] mul_b;
    logic [PW-1:0] mul_p;

    tmu2_mult2_arb #(.A_WIDTH(AW), .B_WIDTH(BW)) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .busy     (busy),
        .s0_stb_i (s0_stb_i),
        .s0_ack_o (s0_ack_o),
        .s0_a     (s0_a),
        .s0_b     (s0_b),
        .s1_stb_i (s1_stb_i),
        .s1_ack_o (s1_ack_o),
        .s1_a     (s1_a),
        .s1_b     (s1_b),
        .r0_stb_o (r0_stb_o),
        .r0_ack_i (r0_ack_i),
        .r1_stb_o (r1_stb_o),
        .r1_ack_i (r1_ack_i),
        .r_p      (r_p),
        .mul_ce   (mul_ce),
        .mul_a    (mul_a),
        .mul_b    (mul_b),
        .mul_p    (mul_p)
    );

    always #5 sys_clk = ~sys_clk;

    // External multiplier: operands -> temp -> p, advancing only on ce.
    // Contents are deliberately not reset.
    logic [PW-1:0] m_temp = '0;
    logic [PW-1:0] m_p    = '0;
    always @(posedge sys_clk) begin
        if (mul_ce) begin
            m_temp <= PW'(mul_a) * PW'(mul_b);
            m_p    <= m_temp;
        end
    end
    assign mul_p = m_p;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic          id;
        logic [PW-1:0] p;
        int            t;
    } item_t;

    item_t sb_q[$];

    // ------------------------------------------------------------------
    // Issue-side predictor: who should be acked this cycle, and what
    // product that issue must eventually return.
    // ------------------------------------------------------------------
    logic model_last = 1'b1;
    always @(negedge sys_clk) begin
        logic exp_ce, exp_issue, win;
        item_t it;
        if (sys_rst) begin
            model_last = 1'b1;
        end else begin
            exp_ce = !((r0_stb_o && !r0_ack_i) || (r1_stb_o && !r1_ack_i));
            check("mul_ce", 32'(mul_ce), 32'(exp_ce));
            exp_issue = exp_ce && (s0_stb_i || s1_stb_i);
`ifdef TMU2_MULTARB_RR_EN
            win = (s0_stb_i && s1_stb_i) ? !model_last : s1_stb_i;
`else
            win = !s0_stb_i && s1_stb_i;
`endif
            check("s0_ack", 32'(s0_ack_o), 32'(exp_issue && !win));
            check("s1_ack", 32'(s1_ack_o), 32'(exp_issue && win));
            if (exp_issue) begin
                it.id = win;
                it.p  = win ? PW'(s1_a) * PW'(s1_b) : PW'(s0_a) * PW'(s0_b);
                it.t  = cyc;
                sb_q.push_back(it);
                model_last = win;
            end
        end
    end

    // ------------------------------------------------------------------
    // Result-side monitor: every presented product must be the oldest
    // outstanding one, with the right owner, at the right time.
    // ------------------------------------------------------------------
    always @(negedge sys_clk) begin
        item_t head;
        if (sys_rst) begin
            sb_q.delete();
        end else begin
            check("busy", 32'(busy), 32'(s0_stb_i || s1_stb_i || sb_q.size() != 0));
            if (r0_stb_o || r1_stb_o) begin
                if (sb_q.size() == 0) begin
                    check("spurious_stb", 32'({r0_stb_o, r1_stb_o}), 32'd0);
                end else begin
                    head = sb_q[0];
                    check("r0_stb_owner", 32'(r0_stb_o), 32'(head.id == 1'b0));
                    check("r1_stb_owner", 32'(r1_stb_o), 32'(head.id == 1'b1));
                    check("r_p", 32'(r_p), 32'(head.p));
                    check("latency_early", 32'(cyc - head.t >= 2), 32'd1);
                    if ((r0_stb_o && r0_ack_i) || (r1_stb_o && r1_ack_i))
                        void'(sb_q.pop_front());
                end
            end else if (sb_q.size() != 0 && cyc - sb_q[0].t >= 2) begin
                check("missing_stb", 32'(r0_stb_o | r1_stb_o), 32'd1);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Stimulus helpers. Inputs change 1ns after the rising edge.
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic send(input int id, input logic [AW-1:0] a, input logic [BW-1:0] b);
        logic got;
        got = 1'b0;
        if (id == 0) begin s0_stb_i = 1'b1; s0_a = a; s0_b = b; end
        else         begin s1_stb_i = 1'b1; s1_a = a; s1_b = b; end
        for (int i = 0; i < 30; i++) begin
            @(negedge sys_clk);
            if ((id == 0) ? s0_ack_o : s1_ack_o) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        check("send_acked", 32'(got), 32'd1);
        tick();
        if (id == 0) s0_stb_i = 1'b0;
        else         s1_stb_i = 1'b0;
    endtask

    task automatic drain();
        s0_stb_i = 1'b0;
        s1_stb_i = 1'b0;
        r0_ack_i = 1'b1;
        r1_ack_i = 1'b1;
        for (int i = 0; i < 50 && sb_q.size() != 0; i++) tick();
        tick();
        check("drained", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        tick();
        tick();
        sys_rst = 1'b0;
    endtask

    logic [AW-1:0] a1, a2;
    logic [BW-1:0] b1, b2;
    logic          acked0, acked1;
    int            order[$];

    initial begin
        // Reset: outputs quiet, busy follows the request inputs.
        tick();
        s0_stb_i = 1'b1;
        @(negedge sys_clk);
        check("rst_r0_stb", 32'(r0_stb_o), 32'd0);
        check("rst_r1_stb", 32'(r1_stb_o), 32'd0);
        check("rst_s0_ack", 32'(s0_ack_o), 32'd0);
        check("rst_mul_ce", 32'(mul_ce), 32'd0);
        check("rst_busy_stb", 32'(busy), 32'd1);
        tick();
        s0_stb_i = 1'b0;
        sys_rst  = 1'b0;
        tick();

        // 1: single issue, two-cycle latency.
        send(0, 13'd100, 13'd200);
        @(negedge sys_clk);
        check("t1_r0_stb_t1", 32'(r0_stb_o), 32'd0);
        tick();
        @(negedge sys_clk);
        check("t1_r0_stb_t2", 32'(r0_stb_o), 32'd1);
        check("t1_r_p", 32'(r_p), 32'd20000);
        check("t1_r1_stb", 32'(r1_stb_o), 32'd0);
        drain();

        // 2: max operands, full-width product.
        send(0, 13'h1FFF, 13'h1FFF);
        @(negedge sys_clk);
        tick();
        @(negedge sys_clk);
        check("t2_r_p_max", 32'(r_p), 32'h3FFC001);
        drain();

        // 3: both requesters held for four cycles from a fresh reset.
        do_reset();
        s0_stb_i = 1'b1; s0_a = 13'd3; s0_b = 13'd5;
        s1_stb_i = 1'b1; s1_a = 13'd7; s1_b = 13'd11;
        for (int i = 0; i < 4; i++) begin
            @(negedge sys_clk);
            if (s0_ack_o) order.push_back(0);
            if (s1_ack_o) order.push_back(1);
            tick();
            s0_a = s0_a + 1'b1;
            s1_a = s1_a + 1'b1;
        end
        check("t3_issues", 32'(order.size()), 32'd4);
        for (int i = 0; i < 4 && i < order.size(); i++) begin
`ifdef TMU2_MULTARB_RR_EN
            check("t3_order", 32'(order[i]), 32'(i % 2));
`else
            check("t3_order", 32'(order[i]), 32'd0);
`endif
        end
        drain();

        // 4: owner withholds ack with two products in flight.
        a1 = 13'd1234; b1 = 13'd77;
        a2 = 13'd4321; b2 = 13'd99;
        r0_ack_i = 1'b0;
        send(0, a1, b1);
        send(0, a2, b2);
        s0_stb_i = 1'b1; s0_a = 13'd9; s0_b = 13'd9;
        s1_stb_i = 1'b1; s1_a = 13'd8; s1_b = 13'd8;
        for (int i = 0; i < 3; i++) begin
            @(negedge sys_clk);
            check("t4_mul_ce", 32'(mul_ce), 32'd0);
            check("t4_s0_ack", 32'(s0_ack_o), 32'd0);
            check("t4_s1_ack", 32'(s1_ack_o), 32'd0);
            check("t4_r_p_hold", 32'(r_p), 32'(PW'(a1) * PW'(b1)));
            tick();
        end
        s0_stb_i = 1'b0;
        s1_stb_i = 1'b0;
        r0_ack_i = 1'b1;
        drain();

        // 5: s0 then s1 back-to-back, results in consecutive cycles.
        send(0, 13'd21, 13'd2);
        send(1, 13'd300, 13'd3);
        @(negedge sys_clk);
        check("t5_r0_first", 32'({r0_stb_o, r1_stb_o}), 32'b10);
        check("t5_r_p0", 32'(r_p), 32'd42);
        tick();
        @(negedge sys_clk);
        check("t5_r1_second", 32'({r0_stb_o, r1_stb_o}), 32'b01);
        check("t5_r_p1", 32'(r_p), 32'd900);
        drain();

        // 6: reset while both stages are occupied.
        send(0, 13'd55, 13'd66);
        send(1, 13'd77, 13'd88);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        check("t6_rst_r0", 32'(r0_stb_o), 32'd0);
        check("t6_rst_r1", 32'(r1_stb_o), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        tick();
        sys_rst = 1'b0;
        @(negedge sys_clk);
        check("t6_post_r_stb", 32'({r0_stb_o, r1_stb_o}), 32'd0);
        tick();
        send(1, 13'd123, 13'd45);
        drain();

        // Random traffic: operands held until acked, random result backpressure.
        acked0 = 1'b0;
        acked1 = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (acked0 || !s0_stb_i) begin
                s0_stb_i = ($urandom % 4) != 0;
                s0_a = ($urandom % 8 == 0) ? 13'h1FFF : AW'($urandom);
                s0_b = ($urandom % 8 == 0) ? 13'h1FFF : BW'($urandom);
            end
            if (acked1 || !s1_stb_i) begin
                s1_stb_i = ($urandom % 4) != 0;
                s1_a = AW'($urandom);
                s1_b = BW'($urandom);
            end
            r0_ack_i = ($urandom % 4) != 0;
            r1_ack_i = ($urandom % 3) != 0;
            @(negedge sys_clk);
            acked0 = s0_ack_o;
            acked1 = s1_ack_o;
            tick();
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
